input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Upstream conditioning stage for the flop bank.
- Takes a raw asynchronous level (switch, button, off-board strobe) and passes it through an N-stage synchronizer.
- Accepts a level change only after it has been stable for a programmable number of clocks.
- Outputs the clean registered level plus one-cycle rise/fall pulses, ready to drive the downstream D-flop data and enable inputs.

Parameters:
- SYNC_STAGES, 2, synchronizer depth; legal range >= 2.
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples required to accept a change; legal range >= 1.
- RESET_VAL, 1'b0, value of dout and of every synchronizer stage while in reset.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- din  input  1  raw asynchronous level.
- enable  input  1  synchronous qualifier; low freezes acceptance of changes.
- dout  output  1  debounced, synchronized level.
- rise_pulse  output  1  one-cycle high when dout goes 0->1.
- fall_pulse  output  1  one-cycle high when dout goes 1->0.
- busy  output  1  high while a candidate change is being counted.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - reset is asynchronous and active-low; all flops use posedge clk / negedge reset.
- Reset values (applied immediately on reset low):
  - All sync stages = RESET_VAL; dout = RESET_VAL.
  - rise_pulse = 0, fall_pulse = 0, busy = 0.
  - State = STABLE, cnt = 0.
  - No pulse is generated on reset release.
- Synchronizer:
  - Shift chain of SYNC_STAGES flops; s = last stage.
  - Runs every cycle regardless of enable.
- FSM states: STABLE, COUNTING. Transitions are evaluated at each posedge.
  - STABLE:
    - If enable and s != dout: go to COUNTING, cnt = 1.
    - If DEBOUNCE_CYCLES == 1: update dout directly instead and stay in STABLE.
  - COUNTING, first match wins:
    - enable == 0: go to STABLE, cnt = 0, dout unchanged.
    - s == dout (glitch): go to STABLE, cnt = 0, no pulse.
    - cnt == DEBOUNCE_CYCLES-1: dout <= s, fire the matching pulse, go to STABLE, cnt = 0.
    - Otherwise: cnt++.
- Outputs and timing:
  - busy is registered and equals (state == COUNTING).
  - rise_pulse and fall_pulse are registered and asserted in the same cycle dout changes, high for exactly one cycle.
  - The two pulses are never high together.
- Latency:
  - Define din changed before edge 1.
  - s changes after edge SYNC_STAGES.
  - dout changes at edge SYNC_STAGES + DEBOUNCE_CYCLES, which is edge 6 with defaults.
- Back-to-back changes: after an accepted change, the next opposite change needs a full new count; no pipelining of candidates.
- Reset mid-count aborts with no pulse. After release, a full SYNC_STAGES + DEBOUNCE_CYCLES delay is required again.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Decomposition:
- Shared package (rtl_pkg):
  - State typedef {STABLE, COUNTING}.
  - Default constants DEF_SYNC_STAGES = 2 and DEF_DEBOUNCE_CYCLES = 4.
- One sub-module, sync_chain:
  - Parameters WIDTH and STAGES, plus a reset value.
  - Uses the same clk and asynchronous active-low reset.
  - Instantiated once with WIDTH = 1.
- FSM, counter and pulse logic stay in input_debouncer.

Test Plan:
- Reset and idle: reset low for 3 cycles with din = 0 -> dout = 0, pulses = 0, busy = 0; hold din = 0 for 20 cycles after release -> no pulses, busy stays 0.
- Clean rise: din 0->1 before edge 1, held -> busy = 1 after edges 3-5, dout = 1 at edge 6, rise_pulse high only for the cycle after edge 6.
- Glitch reject: din high for edges 1-3, low afterwards -> busy pulses high briefly, dout stays 0, no rise_pulse within 20 cycles.
- Clean fall: from dout = 1, din 1->0 held -> dout = 0 at edge 6, fall_pulse high for exactly one cycle, rise_pulse stays 0.
- Enable gating:
  - enable = 0 while din goes 0->1 and is held 10 cycles -> dout = 0, busy = 0.
  - Then raise enable -> dout = 1 exactly 4 edges later, with one rise_pulse.
- Reset mid-count: din 0->1; assert reset low asynchronously between edges 4 and 5 -> busy = 0 immediately; release at edge 8 with din still 1 -> dout = 1 at edge 8+6, one rise_pulse.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared types and default constants for the input debouncer slice.
// The FSM state encoding is also exported on the top-level debug port.
package input_debouncer_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// N-stage flop chain that brings an asynchronous level into the clk domain.
// Every stage resets to RESET_VAL, so the chain starts out agreeing with dout.
module sync_chain
  import input_debouncer_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = DEF_SYNC_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  // Stage 0 takes the raw input; the last stage is the only one used downstream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes a raw level, accepts a change only after it is stable for
// DEBOUNCE_CYCLES enabled samples, and emits registered rise/fall pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL       = 1'b0,
  localparam int  CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic enable,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy,
  output logic dbg_state
);

  // Handshake: none. enable is a level qualifier sampled on every posedge;
  // outputs are registered and valid every cycle outside reset.

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_s;
  logic             w_accept;
  logic             r_dout;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;
  logic             w_dout_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_busy_nxt;

  sync_chain #(
    .WIDTH     (1),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (din),
    .o_q     (w_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_dout  <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // A single-cycle debounce accepts straight from STABLE and never counts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      STABLE: begin
        if (enable && (w_s != r_dout)) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = COUNTING;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      COUNTING: begin
        if (!enable || (w_s == r_dout)) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_accept    = 1'b1;
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_dout_nxt = w_accept ? w_s : r_dout;
    w_rise_nxt = w_accept & w_s;
    w_fall_nxt = w_accept & ~w_s;
    w_busy_nxt = (w_state_nxt == COUNTING);
  end

  assign dout       = r_dout;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus random levels, checked
// against a run-length reference model through an expected-value queue.
module tb_input_debouncer;

  localparam int   SYNC_STAGES     = 2;
  localparam int   DEBOUNCE_CYCLES = 4;
  localparam logic RESET_VAL       = 1'b0;

  logic clk;
  logic reset;
  logic din;
  logic enable;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
  logic dbg_state;
  logic [3:0] w_obs;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];

  // reference model: din history models the synchronizer delay
  logic m_hist[$];
  logic m_dout;
  int   m_run;

  input_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (RESET_VAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .enable     (enable),
    .dout       (dout),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  assign w_obs = {dout, rise_pulse, fall_pulse, busy};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(RESET_VAL);
    m_dout = RESET_VAL;
    m_run  = 0;
  endtask

  // driver: apply inputs at negedge, predict the outputs after the next posedge
  task automatic step(input logic d, input logic e);
    logic s;
    logic r;
    logic f;
    @(negedge clk);
    din    = d;
    enable = e;
    s = m_hist.pop_front();
    m_hist.push_back(d);
    r = 1'b0;
    f = 1'b0;
    if (e && (s != m_dout)) begin
      m_run++;
      if (m_run == DEBOUNCE_CYCLES) begin
        r      = s;
        f      = ~s;
        m_dout = s;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    exp_q.push_back({m_dout, r, f, (m_run != 0)});
  endtask

  task automatic check_after_edge(input string name, input logic [3:0] exp);
    @(posedge clk);
    #2;
    check(name, w_obs, exp);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", w_obs, {RESET_VAL, 3'b000});
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle_outputs", w_obs, e);
    end
  end

  initial begin
    reset  = 1'b0;
    din    = 1'b0;
    enable = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", w_obs, {RESET_VAL, 3'b000});
    @(posedge clk);
    #3;
    reset = 1'b1;

    // idle
    repeat (20) step(1'b0, 1'b1);

    // clean rise: dout and rise_pulse at edge 6
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      if (i == 6) check_after_edge("rise_at_edge6", 4'b1100);
    end

    // clean fall
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1);
      if (i == 6) check_after_edge("fall_at_edge6", 4'b0010);
    end

    // glitch reject: high for three samples only
    repeat (3) step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);

    // enable gating
    repeat (10) step(1'b1, 1'b0);
    check("gated_hold", w_obs, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1);
      if (i == 4) check_after_edge("enable_release_rise", 4'b1100);
    end
    repeat (10) step(1'b0, 1'b1);

    // reset mid-count between edges 4 and 5, release after edge 8
    repeat (4) step(1'b1, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_count_reset", w_obs, 4'b0000);
    model_reset();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      if (i == 6) check_after_edge("post_reset_rise", 4'b1100);
    end

    // random levels, hold lengths, enable drops and occasional resets
    for (int g = 0; g < 250; g++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
      end else begin
        logic d;
        logic e;
        int   len;
        d   = 1'($urandom_range(0, 1));
        e   = ($urandom_range(0, 7) != 0);
        len = $urandom_range(1, 7);
        repeat (len) step(d, e);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
